// File: rtl/lfsr_run_ctrl_if.sv
// Command/status bundle between the host plus LFSR instance and lfsr_run_ctrl.
// master = host/LFSR side, slave = controller side.
interface lfsr_run_ctrl_if #(
  parameter int LFSR_W = 20,
  parameter int STEP_W = 20,
  parameter int PAT_W  = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic [LFSR_W-1:0] seed;
  logic [STEP_W-1:0] num_steps;
  logic [PAT_W-1:0]  pattern;
  logic              lfsr_bit;

  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_seed;
  logic              lfsr_en;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              match_pulse;
  logic [CNT_W-1:0]  match_count;

  modport master (
    output start, abort, seed, num_steps, pattern, lfsr_bit,
    input  lfsr_load, lfsr_seed, lfsr_en, busy, done, aborted,
           match_pulse, match_count
  );

  modport slave (
    input  start, abort, seed, num_steps, pattern, lfsr_bit,
    output lfsr_load, lfsr_seed, lfsr_en, busy, done, aborted,
           match_pulse, match_count
  );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// Run sequencer for the 20-bit XNOR LFSR: seeds it, steps it num_steps times
// and counts (overlapping) occurrences of a bit pattern in the shifted-out stream.
//
// state | meaning
// IDLE  | waiting for start; inputs latched on acceptance
// LOAD  | one cycle, LFSR loads lfsr_seed
// RUN   | LFSR shifts every cycle, bit stream matched against pattern
// DONE  | one-cycle done pulse, results held
module lfsr_run_ctrl #(
  parameter int LFSR_W = 20,
  parameter int STEP_W = 20,
  parameter int PAT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  lfsr_run_ctrl_if.slave bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q;

  logic [LFSR_W-1:0] seed_q;
  logic [STEP_W-1:0] steps_q;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  hist_q;
  logic [STEP_W-1:0] step_q;
  logic [FILL_W-1:0] fill_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              load_q;
  logic              en_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic              pulse_q;

  logic [PAT_W-1:0]  hist_d;
  logic [STEP_W-1:0] step_d;
  logic [FILL_W-1:0] fill_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              match_d;
  logic              last_step;

  generate
    if (PAT_W == 1) begin : g_hist_one
      assign hist_d = bus.lfsr_bit;
    end else begin : g_hist_shift
      assign hist_d = {hist_q[PAT_W-2:0], bus.lfsr_bit};
    end
  endgenerate

  // fill_d already includes the bit sampled this cycle
  assign fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
  assign match_d   = (fill_d == FILL_MAX) && (hist_d == pat_q);
  assign step_d    = step_q + 1'b1;
  assign last_step = (step_d == steps_q);
  assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      seed_q    <= '0;
      steps_q   <= '0;
      pat_q     <= '0;
      hist_q    <= '0;
      step_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      load_q    <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // results are cleared on entry so they already read zero in LOAD
            seed_q    <= bus.seed;
            steps_q   <= bus.num_steps;
            pat_q     <= bus.pattern;
            hist_q    <= '0;
            step_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            load_q    <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end

        LOAD: begin
          load_q <= 1'b0;
          if (steps_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            en_q    <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          hist_q <= hist_d;
          step_q <= step_d;
          fill_q <= fill_d;
          if (match_d) begin
            pulse_q <= 1'b1;
            cnt_q   <= cnt_d;
          end
          if (last_step || bus.abort) begin
            aborted_q <= bus.abort && !last_step;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          load_q  <= 1'b0;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.lfsr_load   = load_q;
  assign bus.lfsr_seed   = seed_q;
  assign bus.lfsr_en     = en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.match_pulse = pulse_q;
  assign bus.match_count = cnt_q;

endmodule
